// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 3x4 matrix keypad scanner with debounce and key decode
// Define KEYPAD_PULSE_EN for one-clock output pulses per accepted key instead of level outputs.
module keypad_scanner #(
   parameter int SCAN_DIV       = 4,
   parameter int DEBOUNCE_SCANS = 3
) (
   input  logic       clock,
   input  logic       reset,
   output logic [2:0] col_n,
   input  logic [3:0] row_n,
   output logic [9:0] keypad,
   output logic       startn,
   output logic       clearn,
   output logic       key_valid
);
   localparam logic [7:0] SLOT_LAST = 8'(SCAN_DIV - 1);
   localparam logic [3:0] DEB_MAX   = 4'(DEBOUNCE_SCANS);
   localparam logic [3:0] NONE      = 4'hF;
   localparam logic [3:0] CODE_STAR = 4'd9;
   localparam logic [3:0] CODE_ZERO = 4'd10;
   localparam logic [3:0] CODE_HASH = 4'd11;

   typedef enum logic {IDLE, HELD} state_t;

   state_t     state_q;
   logic [3:0] row_s1_q, row_s2_q;
   logic [7:0] slot_q;
   logic [1:0] col_q;
   logic [2:0] col_n_q;
   logic [1:0] hits_q, hits_d;
   logic [3:0] code_q, code_d;
   logic [3:0] prev_q, held_q, deb_q, deb_d;
   logic [3:0] result;
   logic [9:0] keypad_q, keypad_d;
   logic       startn_q, startn_d, clearn_q, clearn_d, key_valid_q;
   logic       accept;

   // Key code is row*3+col; hits saturate at 2 so any multi-key scan reads as NONE.
   always_comb begin
      hits_d = hits_q;
      code_d = code_q;
      for (int r = 0; r < 4; r++) begin
         if (!row_s2_q[r]) begin
            if (hits_d != 2'd2) hits_d = hits_d + 2'd1;
            code_d = 4'(r * 3) + {2'b00, col_q};
         end
      end
      result = (hits_d == 2'd1) ? code_d : NONE;

      if (result != prev_q)     deb_d = 4'd1;
      else if (deb_q == DEB_MAX) deb_d = deb_q;
      else                      deb_d = deb_q + 4'd1;

      keypad_d = '0;
      startn_d = 1'b1;
      clearn_d = 1'b1;
      case (result)
         CODE_STAR: clearn_d = 1'b0;
         CODE_ZERO: keypad_d = 10'd1;
         CODE_HASH: startn_d = 1'b0;
         default:   if (result < CODE_STAR) keypad_d = 10'd2 << result;
      endcase

      accept = (deb_d == DEB_MAX) &&
               ((state_q == IDLE) ? (result != NONE) : (result != held_q));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         row_s1_q    <= 4'hF;
         row_s2_q    <= 4'hF;
         slot_q      <= '0;
         col_q       <= '0;
         col_n_q     <= 3'b110;
         hits_q      <= '0;
         code_q      <= '0;
         prev_q      <= NONE;
         held_q      <= NONE;
         deb_q       <= '0;
         keypad_q    <= '0;
         startn_q    <= 1'b1;
         clearn_q    <= 1'b1;
         key_valid_q <= 1'b0;
      end else begin
         row_s1_q <= row_n;
         row_s2_q <= row_s1_q;
`ifdef KEYPAD_PULSE_EN
         keypad_q    <= '0;
         startn_q    <= 1'b1;
         clearn_q    <= 1'b1;
         key_valid_q <= 1'b0;
`endif
         if (slot_q == SLOT_LAST) begin
            slot_q  <= '0;
            col_q   <= (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
            col_n_q <= {col_n_q[1:0], col_n_q[2]};
            if (col_q == 2'd2) begin
               hits_q <= '0;
               code_q <= '0;
               prev_q <= result;
               deb_q  <= deb_d;
               if (accept) begin
                  state_q     <= (result == NONE) ? IDLE : HELD;
                  held_q      <= result;
                  keypad_q    <= keypad_d;
                  startn_q    <= startn_d;
                  clearn_q    <= clearn_d;
                  key_valid_q <= (result != NONE);
               end
            end else begin
               hits_q <= hits_d;
               code_q <= code_d;
            end
         end else begin
            slot_q <= slot_q + 8'd1;
         end
      end
   end

   assign col_n     = col_n_q;
   assign keypad    = keypad_q;
   assign startn    = startn_q;
   assign clearn    = clearn_q;
   assign key_valid = key_valid_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - randomized bench for keypad_scanner against a scan-level reference model
module tb_keypad_scanner;
   localparam int SD  = 4;
   localparam int DEB = 3;

   logic        clock = 1'b0;
   logic        reset;
   logic [2:0]  col_n;
   logic [3:0]  row_n;
   logic [9:0]  keypad;
   logic        startn, clearn, key_valid;
   logic [11:0] pressed = '0;

   int n_checks = 0;
   int n_pass   = 0;

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DEB)) dut (
      .clock(clock), .reset(reset), .col_n(col_n), .row_n(row_n),
      .keypad(keypad), .startn(startn), .clearn(clearn), .key_valid(key_valid)
   );

   always #5 clock = ~clock;

   // Physical matrix: key (r,c) pulls row r low while column c is driven low.
   assign row_n = {~|(pressed[9 +: 3] & ~col_n), ~|(pressed[6 +: 3] & ~col_n),
                   ~|(pressed[3 +: 3] & ~col_n), ~|(pressed[0 +: 3] & ~col_n)};

   // Reference model: time-indexed scan schedule, per-scan result, run-length debounce.
   int          m_e, m_hits, m_code, m_last, m_run, m_held, m_res;
   bit          m_pulse;
   logic [11:0] m_p1, m_p2;

   always @(posedge clock) begin
      if (reset) begin
         m_e = 0; m_hits = 0; m_code = 0; m_last = -1; m_run = 0; m_held = -1;
         m_pulse = 1'b0; m_p1 = '0; m_p2 = '0;
      end else begin
         m_pulse = 1'b0;
         if (m_e % SD == SD - 1) begin
            for (int r = 0; r < 4; r++)
               if (m_p2[r * 3 + (m_e / SD) % 3]) begin
                  m_hits++;
                  m_code = r * 3 + (m_e / SD) % 3;
               end
            if ((m_e / SD) % 3 == 2) begin
               m_res  = (m_hits == 1) ? m_code : -1;
               m_run  = (m_res == m_last) ? ((m_run < DEB) ? m_run + 1 : DEB) : 1;
               m_last = m_res;
               if (m_run == DEB && m_res != m_held) begin
                  m_held  = m_res;
                  m_pulse = (m_res >= 0);
               end
               m_hits = 0;
            end
         end
         m_p2 = m_p1;
         m_p1 = pressed;
         m_e++;
      end
   end

   function automatic logic [15:0] exp_outs();
      logic [9:0] kp;
      logic       st, cl, kv;
      int         h;
      h = m_held;
`ifdef KEYPAD_PULSE_EN
      if (!m_pulse) h = -1;
`endif
      kp = '0; st = 1'b1; cl = 1'b1; kv = (h >= 0);
      if (h >= 0 && h <= 8) kp = 10'(1 << (h + 1));
      if (h == 10) kp = 10'd1;
      if (h == 11) st = 1'b0;
      if (h == 9)  cl = 1'b0;
      return {~3'(1 << ((m_e / SD) % 3)), kp, st, cl, kv};
   endfunction

   task automatic test_reset();
      pressed = '0;
      reset   = 1'b1;
      repeat (2) @(negedge clock);
      n_checks++;
      if ({col_n, keypad, startn, clearn, key_valid} !== {3'b110, 10'd0, 1'b1, 1'b1, 1'b0})
         $display("FAIL reset_state got %b want %b", {col_n, keypad, startn, clearn, key_valid},
                  {3'b110, 10'd0, 3'b110});
      else n_pass++;
      reset = 1'b0;
      for (int c = 0; c < 3 * SD * 2; c++) begin
         @(negedge clock);
         n_checks++;
         if (col_n !== ~3'(1 << (((c + 1) / SD) % 3)))
            $display("FAIL col_step cyc %0d got %b want %b", c, col_n, ~3'(1 << (((c + 1) / SD) % 3)));
         else n_pass++;
      end
   endtask

`ifndef KEYPAD_PULSE_EN
   task automatic test_digit2();
      pressed = 12'd1 << 1;
      for (int c = 0; c < 260; c++) begin
         @(negedge clock);
         n_checks++;
         if ({col_n, keypad, startn, clearn, key_valid} !== exp_outs())
            $display("FAIL digit2 cyc %0d got %b want %b", c, {col_n, keypad, startn, clearn, key_valid}, exp_outs());
         else n_pass++;
         if (c == 199) begin
            n_checks++;
            if ({keypad, key_valid} !== {10'b0000000100, 1'b1})
               $display("FAIL digit2_held got %b want %b", {keypad, key_valid}, {10'b0000000100, 1'b1});
            else n_pass++;
            pressed = '0;
         end
      end
      n_checks++;
      if ({keypad, key_valid} !== 11'd0)
         $display("FAIL digit2_release got %b want 0", {keypad, key_valid});
      else n_pass++;
   endtask

   task automatic test_hash_star();
      for (int k = 0; k < 2; k++) begin
         pressed = (k == 0) ? (12'd1 << 11) : (12'd1 << 9);
         for (int c = 0; c < 160; c++) begin
            @(negedge clock);
            n_checks++;
            if ({col_n, keypad, startn, clearn, key_valid} !== exp_outs())
               $display("FAIL hash_star cyc %0d got %b want %b", c, {col_n, keypad, startn, clearn, key_valid}, exp_outs());
            else n_pass++;
            if (c == 99) begin
               n_checks++;
               if ({keypad, startn, clearn, key_valid} !== ((k == 0) ? 13'b0000000000_011 : 13'b0000000000_101))
                  $display("FAIL hash_star_held k=%0d got %b", k, {keypad, startn, clearn, key_valid});
               else n_pass++;
               pressed = '0;
            end
         end
      end
   endtask

   task automatic test_bounce();
      for (int c = 0; c < 180; c++) begin
         if (c < 60) pressed = ((c / 5) % 2 == 0) ? (12'd1 << 4) : 12'd0;
         else        pressed = 12'd1 << 4;
         @(negedge clock);
         n_checks++;
         if ({col_n, keypad, startn, clearn, key_valid} !== exp_outs())
            $display("FAIL bounce cyc %0d got %b want %b", c, {col_n, keypad, startn, clearn, key_valid}, exp_outs());
         else n_pass++;
      end
      n_checks++;
      if (keypad !== 10'b0000100000) $display("FAIL bounce_final got %b want 0000100000", keypad);
      else n_pass++;
      pressed = '0;
      repeat (60) @(negedge clock);
   endtask

   task automatic test_multi();
      pressed = (12'd1 << 0) | (12'd1 << 3);
      for (int c = 0; c < 200; c++) begin
         @(negedge clock);
         n_checks++;
         if ({col_n, keypad, startn, clearn, key_valid} !== exp_outs())
            $display("FAIL multi cyc %0d got %b want %b", c, {col_n, keypad, startn, clearn, key_valid}, exp_outs());
         else n_pass++;
         if (c == 99) begin
            n_checks++;
            if ({keypad, startn, clearn, key_valid} !== 13'b0000000000_110)
               $display("FAIL multi_idle got %b want 0000000000110", {keypad, startn, clearn, key_valid});
            else n_pass++;
            pressed = 12'd1 << 0;
         end
      end
      n_checks++;
      if (keypad !== 10'b0000000010) $display("FAIL multi_release4 got %b want 0000000010", keypad);
      else n_pass++;
      pressed = '0;
      repeat (60) @(negedge clock);
   endtask

   task automatic test_back_to_back();
      pressed = 12'd1 << 6;
      for (int c = 0; c < 160; c++) begin
         @(negedge clock);
         if (c == 79) pressed = 12'd1 << 7;
         if (c >= 80) begin
            n_checks++;
            if (key_valid !== 1'b1) $display("FAIL b2b_no_gap cyc %0d got %b want 1", c, key_valid);
            else n_pass++;
         end
      end
      n_checks++;
      if (keypad !== 10'b0100000000) $display("FAIL b2b_final got %b want 0100000000", keypad);
      else n_pass++;
      pressed = '0;
      repeat (60) @(negedge clock);
   endtask

   task automatic test_reset_mid_press();
      pressed = 12'd1 << 2;
      for (int c = 0; c < 180; c++) begin
         reset = (c == 80);
         @(negedge clock);
         n_checks++;
         if ({col_n, keypad, startn, clearn, key_valid} !== exp_outs())
            $display("FAIL reset_mid cyc %0d got %b want %b", c, {col_n, keypad, startn, clearn, key_valid}, exp_outs());
         else n_pass++;
      end
      reset = 1'b0;
      pressed = '0;
      repeat (60) @(negedge clock);
   endtask
`else
   task automatic test_pulse();
      int hits;
      hits = 0;
      pressed = 12'd1 << 8;
      for (int c = 0; c < 200; c++) begin
         @(negedge clock);
         if (keypad === 10'b1000000000) hits++;
         n_checks++;
         if ({col_n, keypad, startn, clearn, key_valid} !== exp_outs())
            $display("FAIL pulse cyc %0d got %b want %b", c, {col_n, keypad, startn, clearn, key_valid}, exp_outs());
         else n_pass++;
      end
      n_checks++;
      if (hits != 1) $display("FAIL pulse_width got %0d clocks want 1", hits);
      else n_pass++;
      pressed = '0;
      repeat (60) @(negedge clock);
   endtask
`endif

   task automatic test_random();
      logic [11:0] pat;
      int          kind, hold;
      for (int it = 0; it < 16; it++) begin
         kind = $urandom_range(0, 5);
         pat  = 12'd1 << $urandom_range(0, 11);
         if (kind == 0) pat = '0;
         if (kind == 1) pat = pat | (12'd1 << $urandom_range(0, 11));
         hold = $urandom_range(20, 130);
         for (int c = 0; c < hold; c++) begin
            if (c < 15 && $urandom_range(0, 2) == 0) pressed = '0;
            else pressed = pat;
            @(negedge clock);
            n_checks++;
            if ({col_n, keypad, startn, clearn, key_valid} !== exp_outs())
               $display("FAIL random it %0d cyc %0d got %b want %b", it, c,
                        {col_n, keypad, startn, clearn, key_valid}, exp_outs());
            else n_pass++;
         end
      end
      pressed = '0;
   endtask

   initial begin
      test_reset();
`ifndef KEYPAD_PULSE_EN
      test_digit2();
      test_hash_star();
      test_bounce();
      test_multi();
      test_back_to_back();
      test_reset_mid_press();
`else
      test_pulse();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 4: clocks each column is driven before rows are sampled; legal range 3..255.
REQ-002 Parameter DEBOUNCE_SCANS, default 3: consecutive identical full-scan results required to accept a change; legal range 1..15.
REQ-003 clock  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 col_n  output  3  matrix column drive, active-low, exactly one bit low at any time.
REQ-006 row_n  input  4  matrix row sense, active-low, externally pulled up, asynchronous to clock.
REQ-007 keypad  output  10  one-hot digit code, bit k = digit k, all-zero when no digit is held.
REQ-008 startn  output  1  active-low, low while '#' is held and debounced.
REQ-009 clearn  output  1  active-low, low while '*' is held and debounced.
REQ-010 key_valid  output  1  high while any debounced key is held.

Function
REQ-011 Key map (row,col): r0: 1,2,3; r1: 4,5,6; r2: 7,8,9; r3: *,0,#.
REQ-012 row_n passes through a 2-flop synchronizer before any use.
REQ-013 Column slot counter counts 0..SCAN_DIV-1; col_n steps 110 -> 101 -> 011 -> 110 on slot wrap.
REQ-014 Synchronized rows are sampled in the last clock of each slot; one full scan = 3*SCAN_DIV clocks.
REQ-015 Scan result at end of column 2: NONE (no row low), KEY(code 0..11) (exactly one row/column hit), or MULTI (two or more hits).
REQ-016 MULTI is treated as NONE.
REQ-017 Debounce counter: result equal to previous scan result -> increment, saturating at DEBOUNCE_SCANS; different -> set to 1.
REQ-018 FSM states IDLE and HELD; IDLE -> HELD when counter reaches DEBOUNCE_SCANS with a KEY result; HELD -> IDLE when it reaches DEBOUNCE_SCANS with NONE.
REQ-019 HELD -> HELD with the new key when DEBOUNCE_SCANS consecutive scans return a different KEY; outputs switch directly, with no all-zero cycle.
REQ-020 Outputs are registered and update one clock after the acceptance scan ends.
REQ-021 In HELD: keypad holds one-hot of the held digit, or zero for '*' / '#'; startn and clearn follow the held key; key_valid = 1.
REQ-022 In IDLE: keypad = 0, startn = 1, clearn = 1, key_valid = 0.
REQ-023 At most one of keypad bits, startn low, or clearn low is active at any time.

Reset
REQ-024 While reset is high at a clock edge: col_n = 110, slot counter 0, synchronizer flops 1111, previous result NONE, debounce counter 0, FSM IDLE, keypad = 0, startn = 1, clearn = 1, key_valid = 0.
REQ-025 Reset mid-press drops all outputs on the next edge; a still-held key is re-accepted only after DEBOUNCE_SCANS full scans following reset release.

Configuration
REQ-026 Macro KEYPAD_PULSE_EN: when defined, keypad, startn, clearn and key_valid assert for exactly one clock at each IDLE->HELD or HELD->HELD key change, and stay inactive while the key remains held.
REQ-027 When KEYPAD_PULSE_EN is undefined, outputs are level-held per REQ-021.

Verification (defaults SCAN_DIV=4, DEBOUNCE_SCANS=3, level mode)
REQ-028 Reset high 2 clocks -> col_n=110, keypad=0, startn=1, clearn=1, key_valid=0; col_n steps every 4 clocks after release.
REQ-029 Digit 2 (r0,c1) held 200 clocks -> keypad=0000000100 and key_valid=1 by at most 3 scans (36 clocks) plus sync latency; release -> keypad=0 after 3 NONE scans.
REQ-030 '#' held -> startn=0, keypad=0, key_valid=1; '*' held -> clearn=0.
REQ-031 Bounce: digit 5 toggled every 5 clocks for 60 clocks, then steady -> no output change during bouncing; keypad=0000100000 after 3 stable scans.
REQ-032 Digits 1 and 4 pressed together -> MULTI, outputs stay idle; 4 released -> keypad=0000000010.
REQ-033 KEYPAD_PULSE_EN defined, digit 9 held 200 clocks -> keypad=1000000000 for exactly one clock, then 0.
